// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   - arb_state_e : arbiter FSM state (IDLE, ACK)
//   - owner_e     : which requester drives the memory port this cycle
//   - DW_DEF / AW_DEF / STARVE_LIMIT_DEF : parameter defaults
//   - STARVE_W / STALL_W : counter widths
package dmem_arb_pkg;

  localparam int DW_DEF           = 16;
  localparam int AW_DEF           = 16;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int STARVE_W         = 4;
  localparam int STALL_W          = 16;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_e;

endpackage

// File: rtl/dmem_starve_ctr.sv
// Saturating starvation counter for the loader.
// Ports:
//   clock    : rising-edge clock
//   reset    : asynchronous active-low reset, clears the count
//   inc      : add one (saturates at LIMIT)
//   clr      : clear to zero (wins over inc)
//   cnt      : current count
//   at_limit : count has reached LIMIT
module dmem_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                inc,
  input  logic                clr,
  output logic [STARVE_W-1:0] cnt,
  output logic                at_limit
);

  localparam logic [STARVE_W-1:0] LIMIT_V = STARVE_W'(LIMIT);

  logic [STARVE_W-1:0] cnt_d;
  logic [STARVE_W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT_V)) begin
      cnt_d = cnt_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign at_limit = (cnt_q == LIMIT_V);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between a CPU (priority, zero latency)
// and a loader (request/grant/ack handshake with starvation protection).
// Ports:
//   clock, reset          : clock and asynchronous active-low reset
//   cpu_addr/wdata/write/read, cpu_rdata, cpu_stall : CPU side
//   ldr_req/we/addr/wdata, ldr_gnt/ack/rdata        : loader side
//   mem_addr/wdata/write/read, mem_rdata            : memory port
//   stall_cnt             : saturating count of CPU stall cycles
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DW           = DW_DEF,
  parameter int AW           = AW_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [AW-1:0]      cpu_addr,
  input  logic [DW-1:0]      cpu_wdata,
  input  logic               cpu_write,
  input  logic               cpu_read,
  output logic [DW-1:0]      cpu_rdata,
  output logic               cpu_stall,
  input  logic               ldr_req,
  input  logic               ldr_we,
  input  logic [AW-1:0]      ldr_addr,
  input  logic [DW-1:0]      ldr_wdata,
  output logic               ldr_gnt,
  output logic               ldr_ack,
  output logic [DW-1:0]      ldr_rdata,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  output logic               mem_write,
  output logic               mem_read,
  input  logic [DW-1:0]      mem_rdata,
  output logic [STALL_W-1:0] stall_cnt
);

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (v == {STALL_W{1'b1}}) ? v : v + STALL_W'(1);
  endfunction

  arb_state_e           state_d, state_q;
  logic                 ldr_ack_d, ldr_ack_q;
  logic [DW-1:0]        ldr_rdata_d, ldr_rdata_q;
  logic [STALL_W-1:0]   stall_cnt_d, stall_cnt_q;

  logic                 cpu_access;
  logic                 in_idle;
  logic                 starve_hit;
  logic                 starve_inc;
  logic                 starve_clr;
  logic [STARVE_W-1:0]  starve_cnt;
  owner_e               owner;

  // Starvation counter only moves in IDLE; in ACK both controls are low
  // so the count holds while the loader's request is ignored.
  dmem_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clock    (clock),
    .reset    (reset),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .cnt      (starve_cnt),
    .at_limit (starve_hit)
  );

  always_comb begin
    cpu_access = cpu_read | cpu_write;
    in_idle    = (state_q == IDLE);
    // CPU has priority unless the loader has been denied STARVE_LIMIT times.
    ldr_gnt    = in_idle & ldr_req & (~cpu_access | starve_hit);
    starve_inc = in_idle & ldr_req & ~ldr_gnt;
    starve_clr = in_idle & (ldr_gnt | ~ldr_req);
    owner      = ldr_gnt ? OWN_LDR : OWN_CPU;
  end

  // Memory port mux: exactly one owner per cycle, pass-through for the CPU.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_write = cpu_write;
    mem_read  = cpu_read;
    cpu_rdata = mem_rdata;
    if (owner == OWN_LDR) begin
      mem_addr  = ldr_addr;
      mem_wdata = ldr_wdata;
      mem_write = ldr_we;
      mem_read  = ~ldr_we;
      cpu_rdata = '0;
    end
  end

  assign cpu_stall = cpu_access & ldr_gnt;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = ldr_gnt ? ACK : IDLE;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ldr_ack_d   = (state_d == ACK);
    // Read data captured at the end of the grant cycle only for reads.
    ldr_rdata_d = (ldr_gnt & ~ldr_we) ? mem_rdata : ldr_rdata_q;
    stall_cnt_d = cpu_stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ldr_ack_q   <= 1'b0;
      ldr_rdata_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ldr_ack_q   <= ldr_ack_d;
      ldr_rdata_q <= ldr_rdata_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ldr_ack   = ldr_ack_q;
  assign ldr_rdata = ldr_rdata_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters (name, default, meaning):
- DW, 16, data width
- AW, 16, address width
- STARVE_LIMIT, 4, max consecutive denied loader cycles before forced grant (1..15)

REQ-002 Ports (name, direction, width, meaning):
- clock, in, 1, single clock, rising edge
- reset, in, 1, asynchronous, active-low reset
- cpu_addr, in, AW, CPU data address
- cpu_wdata, in, DW, CPU write data
- cpu_write, in, 1, CPU write enable
- cpu_read, in, 1, CPU read enable
- cpu_rdata, out, DW, CPU read data
- cpu_stall, out, 1, CPU access blocked this cycle
- ldr_req, in, 1, loader request, held until ldr_ack
- ldr_we, in, 1, loader write (1) / read (0)
- ldr_addr, in, AW, loader address
- ldr_wdata, in, DW, loader write data
- ldr_gnt, out, 1, loader owns memory port this cycle
- ldr_ack, out, 1, loader access complete, one-cycle pulse
- ldr_rdata, out, DW, registered loader read data
- mem_addr, out, AW, memory address
- mem_wdata, out, DW, memory write data
- mem_write, out, 1, memory write enable
- mem_read, out, 1, memory read enable
- mem_rdata, in, DW, combinational memory read data
- stall_cnt, out, 16, saturating count of cpu_stall cycles (debug)

Function
REQ-003 cpu_access = cpu_read | cpu_write.
REQ-004 FSM states: IDLE, ACK; exactly one memory owner per cycle.
REQ-005 In IDLE, ldr_gnt = ldr_req & (~cpu_access | starve_cnt == STARVE_LIMIT); combinational, same cycle.
REQ-006 Owner = loader when ldr_gnt, else CPU; mem_* driven by the owner; loader owns: mem_write = ldr_we, mem_read = ~ldr_we.
REQ-007 CPU owner: mem_write/mem_read equal cpu_write/cpu_read; both 0 when CPU idle.
REQ-008 cpu_stall = cpu_access & ldr_gnt; CPU holds its request while stalled.
REQ-009 cpu_rdata = mem_rdata when the CPU owns the port, else 0.
REQ-010 IDLE -> ACK on ldr_gnt; ACK -> IDLE unconditionally.
REQ-011 In ACK: ldr_ack = 1, ldr_gnt = 0, ldr_req ignored, CPU owns the port.
REQ-012 ldr_rdata registers mem_rdata at the end of the grant cycle for reads; holds its value otherwise, including after writes.
REQ-013 Minimum loader access spacing: 2 cycles (gnt, ack); next gnt no earlier than the cycle after ack.
REQ-014 starve_cnt, 4-bit:
- +1 in IDLE when ldr_req & ~ldr_gnt, saturating at STARVE_LIMIT
- cleared on ldr_gnt or when ldr_req = 0
- held in ACK
REQ-015 stall_cnt +1 per cycle with cpu_stall = 1; saturates at 0xFFFF, no wrap.
REQ-016 Write data and address pass through combinationally; zero added latency for CPU accesses.

Reset
REQ-017 reset low asynchronously forces: state IDLE, ldr_ack 0, ldr_rdata 0, starve_cnt 0, stall_cnt 0.
REQ-018 During reset, combinational outputs follow REQ-005..009 from IDLE; a loader access in progress is abandoned without ack.

Structure
REQ-019 Shared package dmem_arb_pkg holds: the state enum (IDLE, ACK), the DW/AW defaults, and the STARVE_LIMIT default.
REQ-020 One sub-module, dmem_starve_ctr: the saturating starvation counter with a limit-reached flag.

Verification
REQ-021 CPU idle; loader write addr 0x0010 data 0x1234 -> gnt in cycle N with mem_write 1, ack in N+1, cpu_stall 0 throughout.
REQ-022 cpu_read held every cycle; ldr_req read of 0x0020 -> 4 denied cycles, gnt in cycle 5, cpu_stall 1 for that cycle only, stall_cnt = 1.
REQ-023 Loader read of 0x0020 where memory holds 0xBEEF -> ldr_ack with ldr_rdata 0xBEEF; value held after a subsequent write.
REQ-024 ldr_req held high through ack -> no gnt in the ack cycle; next gnt no earlier than the cycle after ack.
REQ-025 Reset asserted in the gnt cycle -> no ldr_ack, all registers 0 immediately, state IDLE after release.
REQ-026 Force 0xFFFF stall cycles plus 3 more -> stall_cnt stays 0xFFFF.
